hls4ml_mac_pipe_stream: RTL and testbench

//  Parametrised, stall-aware pipelined multiply / multiply-accumulate unit for hls4ml dense layers.

---
 rtl/hls4ml_arith_pkg.sv | 29 ++
 rtl/hls4ml_mul_pipe_core.sv | 43 ++++
 rtl/hls4ml_mac_pipe_stream.sv | 87 ++++++++
 tb/tb_hls4ml_mac_pipe_stream.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/hls4ml_arith_pkg.sv
// hls4ml_arith_pkg: shared width helpers and round/saturate functions for hls4ml arithmetic blocks.
package hls4ml_arith_pkg;
  localparam int MAX_W = 64;
  typedef logic signed [MAX_W:0] wide_t;
  function automatic int ext_w(input int w);
    return w + 1;
  endfunction
  function automatic int prod_w(input int aw, input int bw);
    return aw + bw + 1;
  endfunction
  // One bit wider than any accumulator, so the rounding add cannot wrap.
  function automatic wide_t round_shift(input wide_t x, input int sh, input bit rnd);
    wide_t r;
    r = (rnd && sh > 0) ? (wide_t'(1) <<< (sh - 1)) : wide_t'(0);
    return (x + r) >>> sh;
  endfunction
  function automatic wide_t sat_hi(input int w);
    return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
  endfunction
  function automatic wide_t sat_lo(input int w);
    return -sat_hi(w) - wide_t'(1);
  endfunction
  function automatic logic sat_over(input wide_t y, input int w);
    return y > sat_hi(w) || y < sat_lo(w);
  endfunction
  function automatic wide_t sat_clip(input wide_t y, input int w);
    return y > sat_hi(w) ? sat_hi(w) : y < sat_lo(w) ? sat_lo(w) : y;
  endfunction
endpackage

// File: rtl/hls4ml_mul_pipe_core.sv
// hls4ml_mul_pipe_core: operand extension and exact signed multiply through a NUM_STAGE register chain.
module hls4ml_mul_pipe_core
  import hls4ml_arith_pkg::*;
#(
  parameter int A_W       = 13,
  parameter int A_SIGNED  = 0,
  parameter int B_W       = 14,
  parameter int B_SIGNED  = 1,
  parameter int NUM_STAGE = 2,
  localparam int PW       = prod_w(A_W, B_W)
) (
  input  logic                 clk,
  input  logic                 ce,
  input  logic [A_W-1:0]       a_i,
  input  logic [B_W-1:0]       b_i,
  output logic signed [PW-1:0] prod_o
);
  localparam int AX = ext_w(A_W);
  localparam int BX = ext_w(B_W);
  logic signed [AX-1:0] a_q;
  logic signed [BX-1:0] b_q;
  logic signed [PW-1:0] p;
  // Datapath registers carry no reset so they pack into the DSP; validity travels in the top level.
  always_ff @(posedge clk) begin
    if (ce) begin
      a_q <= A_SIGNED != 0 ? {a_i[A_W-1], a_i} : {1'b0, a_i};
      b_q <= B_SIGNED != 0 ? {b_i[B_W-1], b_i} : {1'b0, b_i};
    end
  end
  assign p = PW'(a_q) * PW'(b_q);
  if (NUM_STAGE == 1) begin : g_comb
    assign prod_o = p;
  end else begin : g_pipe
    logic signed [PW-1:0] r_q [NUM_STAGE-1];
    always_ff @(posedge clk) begin
      if (ce) begin
        r_q[0] <= p;
        for (int s = 1; s < NUM_STAGE - 1; s++) r_q[s] <= r_q[s-1];
      end
    end
    assign prod_o = r_q[NUM_STAGE-2];
  end
endmodule

// File: rtl/hls4ml_mac_pipe_stream.sv
// hls4ml_mac_pipe_stream: stall-aware pipelined multiply / dot-product accumulate with round and saturate.
module hls4ml_mac_pipe_stream
  import hls4ml_arith_pkg::*;
#(
  parameter int A_W       = 13,
  parameter int A_SIGNED  = 0,
  parameter int B_W       = 14,
  parameter int B_SIGNED  = 1,
  parameter int NUM_STAGE = 2,
  parameter int ACC_W     = 32,
  parameter int SHIFT     = 0,
  parameter int ROUND     = 0,
  parameter int SAT       = 1,
  parameter int OUT_W     = 23
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [A_W-1:0]          in_a,
  input  logic [B_W-1:0]          in_b,
  input  logic                    in_mode,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_sat
);
  localparam int PW = prod_w(A_W, B_W);
  logic                    en;
  logic [NUM_STAGE-1:0]    v_q, m_q, l_q;
  logic                    lv, lm, ll;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] prod_x, acc_d, acc_q, res;
  logic                    acc_open_q;
  logic                    produce;
  wide_t                   y;
  logic signed [OUT_W-1:0] out_data_d, out_data_q;
  logic                    out_sat_d, out_sat_q, out_valid_q;
  assign en        = !out_valid_q || out_ready;
  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign lv        = v_q[NUM_STAGE-1];
  assign lm        = m_q[NUM_STAGE-1];
  assign ll        = l_q[NUM_STAGE-1];
  hls4ml_mul_pipe_core #(
    .A_W(A_W), .A_SIGNED(A_SIGNED), .B_W(B_W), .B_SIGNED(B_SIGNED), .NUM_STAGE(NUM_STAGE)
  ) u_core (
    .clk(clk), .ce(en), .a_i(in_a), .b_i(in_b), .prod_o(prod)
  );
  always_comb begin
    prod_x     = ACC_W'(prod);
    acc_d      = (acc_open_q ? acc_q : '0) + prod_x;
    res        = lm ? acc_d : prod_x;
    produce    = lv && (!lm || ll);
    y          = round_shift(wide_t'(res), SHIFT, ROUND != 0);
    out_data_d = OUT_W'(SAT != 0 ? sat_clip(y, OUT_W) : y);
    out_sat_d  = SAT != 0 && sat_over(y, OUT_W);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q         <= '0;
      m_q         <= '0;
      l_q         <= '0;
      acc_q       <= '0;
      acc_open_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else if (en) begin
      v_q         <= (v_q << 1) | NUM_STAGE'(in_valid);
      m_q         <= (m_q << 1) | NUM_STAGE'(in_mode);
      l_q         <= (l_q << 1) | NUM_STAGE'(in_last);
      out_valid_q <= produce;
      if (lv && lm) begin
        acc_q      <= ll ? '0 : acc_d;
        acc_open_q <= !ll;
      end
      if (produce) begin
        out_data_q <= out_data_d;
        out_sat_q  <= out_sat_d;
      end
    end
  end
endmodule

// File: tb/tb_hls4ml_mac_pipe_stream.sv
// tb_hls4ml_mac_pipe_stream: directed vectors with a queue scoreboard per DUT instance.
module tb_hls4ml_mac_pipe_stream;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  logic               in_valid, in_ready, in_mode, in_last, out_valid, out_ready, out_sat;
  logic [12:0]        in_a;
  logic [13:0]        in_b;
  logic signed [22:0] out_data;
  logic               v2, rdy2, rdy3, ov2, ov3, os2, os3;
  logic [12:0]        a2;
  logic [13:0]        b2;
  logic signed [22:0] od2, od3;
  typedef struct packed {logic signed [22:0] d; logic s;} exp_t;
  exp_t q1[$], q2[$], q3[$];
  int checks = 0, errors = 0;
  hls4ml_mac_pipe_stream u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_mode(in_mode), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat)
  );
  hls4ml_mac_pipe_stream #(.SHIFT(4), .ROUND(1)) u2 (
    .clk(clk), .reset(reset), .in_valid(v2), .in_ready(rdy2), .in_a(a2), .in_b(b2),
    .in_mode(1'b0), .in_last(1'b0), .out_valid(ov2), .out_ready(1'b1),
    .out_data(od2), .out_sat(os2)
  );
  hls4ml_mac_pipe_stream #(.SHIFT(4), .ROUND(0)) u3 (
    .clk(clk), .reset(reset), .in_valid(v2), .in_ready(rdy3), .in_a(a2), .in_b(b2),
    .in_mode(1'b0), .in_last(1'b0), .out_valid(ov3), .out_ready(1'b1),
    .out_data(od3), .out_sat(os3)
  );
  task automatic chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL u1_unexpected got %0d expected no output", out_data);
      end else begin
        e = q1.pop_front();
        chk("u1_data", out_data, e.d);
        chk("u1_sat", out_sat, e.s);
      end
    end
  end
  always @(negedge clk) begin
    exp_t e;
    if (!reset && ov2) begin
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL u2_unexpected got %0d expected no output", od2);
      end else begin
        e = q2.pop_front();
        chk("u2_round_data", od2, e.d);
        chk("u2_sat", os2, e.s);
      end
    end
  end
  always @(negedge clk) begin
    exp_t e;
    if (!reset && ov3) begin
      if (q3.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL u3_unexpected got %0d expected no output", od3);
      end else begin
        e = q3.pop_front();
        chk("u3_trunc_data", od3, e.d);
        chk("u3_sat", os3, e.s);
      end
    end
  end
  task automatic send(input int a, input int b, input logic m, input logic l,
                      input bit push, input int ed, input logic es);
    int n = 0;
    in_valid = 1'b1;
    in_a = 13'(a);
    in_b = 14'(b);
    in_mode = m;
    in_last = l;
    if (push) q1.push_back('{d: 23'(ed), s: es});
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n == 100) chk("accept_timeout", n, 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic send2(input int a, input int b, input int e2, input int e3);
    v2 = 1'b1;
    a2 = 13'(a);
    b2 = 14'(b);
    q2.push_back('{d: 23'(e2), s: 1'b0});
    q3.push_back('{d: 23'(e3), s: 1'b0});
    @(posedge clk);
    #1 v2 = 1'b0;
  endtask
  task automatic latency(input string nm);
    int c = 0;
    while (!out_valid && c < 10) begin
      @(posedge clk);
      #1 c++;
    end
    chk(nm, c, 2);
  endtask
  task automatic drain();
    int n = 0;
    while ((q1.size() + q2.size() + q3.size()) != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("drain", q1.size() + q2.size() + q3.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_mode = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b1;
    v2 = 1'b0;
    a2 = '0;
    b2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_in_ready", in_ready, 1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    send(8191, -8192, 0, 0, 1, -4194304, 1);
    latency("t1_latency");
    send(2047, 2049, 0, 0, 1, 4194303, 0);
    send(4096, -1024, 0, 0, 1, -4194304, 0);
    send(4096, 1024, 0, 0, 1, 4194303, 1);
    send(8191, 8191, 0, 0, 1, 4194303, 1);
    drain();
    send(3, 5, 1, 0, 0, 0, 0);
    send(2, -7, 1, 0, 0, 0, 0);
    send(10, 1, 1, 1, 1, 11, 0);
    latency("t2_latency");
    drain();
    send(3, 5, 1, 0, 0, 0, 0);
    send(4, 4, 0, 0, 1, 16, 0);
    send(2, -7, 1, 0, 0, 0, 0);
    send(10, 1, 1, 1, 1, 11, 0);
    drain();
    out_ready = 1'b0;
    fork
      begin
        send(1, 1, 0, 0, 1, 1, 0);
        send(2, 2, 0, 0, 1, 4, 0);
        send(3, 3, 0, 0, 1, 9, 0);
        send(4, 4, 0, 0, 1, 16, 0);
      end
      begin
        repeat (3) @(posedge clk);
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("t3_in_ready", in_ready, 0);
          chk("t3_out_valid", out_valid, 1);
          chk("t3_hold", out_data, 1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    send2(3, 8, 2, 1);
    send2(3, -8, -1, -2);
    drain();
    send(1, 1, 1, 0, 0, 0, 0);
    send(2, 2, 1, 0, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_data", out_data, 0);
    chk("t6_rst_sat", out_sat, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    send(5, 5, 1, 1, 1, 25, 0);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
